// File: rtl/shift_normalizer.sv
// rtl/shift_normalizer.sv - iterative leading-zero normalizer, one left shift per clock
module shift_normalizer #(
    parameter int N    = 8,
    parameter int LOGN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N-1:0]    in,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    out,
    output logic [LOGN-1:0] count,
    output logic            zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    work_q, work_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [N-1:0]    out_q, out_d;
    logic [LOGN-1:0] count_q, count_d;
    logic            zero_q, zero_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        count_d = count_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (in != '0) begin
                        work_d  = in;
                        cnt_d   = '0;
                        zero_d  = 1'b0;
                        state_d = ST_SHIFT;
                    end else begin
                        out_d   = '0;
                        count_d = '0;
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                // A nonzero word reaches its MSB within N-1 shifts, so cnt cannot wrap.
                if (work_q[N-1]) begin
                    out_d   = work_q;
                    count_d = cnt_q;
                    state_d = ST_DONE;
                end else begin
                    work_d = {work_q[N-2:0], 1'b0};
                    cnt_d  = cnt_q + LOGN'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign out   = out_q;
    assign count = count_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// tb/tb_shift_normalizer.sv - directed self-checking bench for shift_normalizer
module tb_shift_normalizer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_w;
    logic       busy;
    logic       done;
    logic [7:0] out_w;
    logic [2:0] count_w;
    logic       zero_w;

    int n_checks;
    int n_errors;
    logic [7:0] last_out;

    shift_normalizer #(.N(8), .LOGN(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in_w),
        .busy  (busy),
        .done  (done),
        .out   (out_w),
        .count (count_w),
        .zero  (zero_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // exp_lat is the index of the post-accept negedge where done must appear
    task automatic run_op(input string tag, input logic [7:0] din, input int exp_lat,
                          input logic [7:0] exp_out, input logic [2:0] exp_cnt,
                          input logic exp_zero);
        int  k;
        int  busy_n;
        bit  seen;
        @(negedge clk);
        start = 1'b1;
        in_w  = din;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_w  = 8'hA5;
        seen   = 1'b0;
        busy_n = 0;
        k      = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (i == 0 && exp_lat > 0) check({tag, "_out_hold"}, 32'(out_w), 32'(last_out));
            if (done) begin
                seen = 1'b1;
                k    = i;
            end
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat + 1));
        check({tag, "_out"}, 32'(out_w), 32'(exp_out));
        check({tag, "_count"}, 32'(count_w), 32'(exp_cnt));
        check({tag, "_zero"}, 32'(zero_w), 32'(exp_zero));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'(0));
        check({tag, "_idle"}, 32'(busy), 32'(0));
        last_out = exp_out;
    endtask

    initial begin
        int  k;
        bit  seen;
        int  done_n;
        n_checks = 0;
        n_errors = 0;
        last_out = 8'h00;
        rst   = 1'b1;
        start = 1'b0;
        in_w  = 8'h00;

        #12;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_out", 32'(out_w), 32'(0));
        check("rst_count", 32'(count_w), 32'(0));
        check("rst_zero", 32'(zero_w), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op("l0",    8'b10011101, 1, 8'b10011101, 3'd0, 1'b0);
        run_op("l2",    8'b00101100, 3, 8'b10110000, 3'd2, 1'b0);
        run_op("l7",    8'b00000001, 8, 8'b10000000, 3'd7, 1'b0);
        run_op("zero",  8'b00000000, 0, 8'b00000000, 3'd0, 1'b1);

        // start held high with in=FF throughout the busy period of a worst-case word
        @(negedge clk);
        start = 1'b1;
        in_w  = 8'b00000001;
        @(posedge clk);
        #1;
        in_w = 8'hFF;
        seen = 1'b0;
        k    = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                k    = i;
            end
        end
        check("rp_latency", 32'(k), 32'(8));
        check("rp_count", 32'(count_w), 32'(7));
        check("rp_out", 32'(out_w), 32'(8'h80));
        check("rp_zero_cleared", 32'(zero_w), 32'(0));
        @(negedge clk);
        check("rp_idle_after_done", 32'(busy), 32'(0));
        @(negedge clk);
        check("rp_second_accept", 32'(busy), 32'(1));
        start = 1'b0;
        @(negedge clk);
        check("rp_ff_done", 32'(done), 32'(1));
        check("rp_ff_out", 32'(out_w), 32'(8'hFF));
        check("rp_ff_count", 32'(count_w), 32'(0));
        @(negedge clk);
        check("rp_ff_idle", 32'(busy), 32'(0));

        // asynchronous reset between edges while shifting
        @(negedge clk);
        start = 1'b1;
        in_w  = 8'b00000001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        check("arst_out", 32'(out_w), 32'(0));
        check("arst_count", 32'(count_w), 32'(0));
        check("arst_zero", 32'(zero_w), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        check("arst_no_done", 32'(done_n), 32'(0));
        last_out = 8'h00;
        run_op("post_rst", 8'b11100101, 1, 8'b11100101, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Sequential inverse of the barrel shifter. The barrel shifter takes a word and a shift amount and produces a shifted word. This block takes a word and recovers the left-shift amount that normalizes it, meaning the amount that puts its first 1 bit in the MSB.
- Iterative: shifts left one bit per clock under a start/busy/done handshake.
- Sits beside the barrel shifter. Its count output can drive the barrel shifter's shift-select input directly.

Parameters:
- N, 8, data word width.
- LOGN, 3, width of the shift-count output; must satisfy 2^LOGN >= N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- in  input  N  word to normalize; sampled on the edge that accepts start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result is valid.
- out  output  N  normalized word, in << count.
- count  output  LOGN  number of leading zeros of the accepted word, i.e. the left-shift amount.
- zero  output  1  accepted word was all zeros.

Behaviour:
- Reset: asynchronous, active-high. Drives state=IDLE, busy=0, done=0, out=0, count=0, zero=0, internal work register=0. Reset mid-operation abandons the operation; no done pulse follows.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 and in!=0: on that edge, work<=in, cnt<=0, zero<=0, go to SHIFT.
  - start=1 and in==0: go to DONE directly with out<=0, count<=0, zero<=1.
  - start=0: stay in IDLE.
- SHIFT, at each edge:
  - work[N-1]==1: out<=work, count<=cnt, go to DONE.
  - Otherwise: work<=work<<1 (zero fill), cnt<=cnt+1.
- DONE: done=1 for exactly this one cycle, then IDLE on the next edge. busy remains 1 in DONE.
- Latency, taking the accepting edge as edge 0 and L as the number of leading zeros (0..N-1):
  - Nonzero word: edges 1..L shift, edge L+1 enters DONE, so done is high during the cycle after edge L+1. Start to done is L+2 cycles; the next start is accepted at edge L+3 at the earliest.
  - Zero word: done is high in the cycle after edge 0.
- cnt never exceeds N-1, so it cannot wrap in LOGN bits.
- start while busy=1, including in DONE, is ignored with no queuing. in is ignored except on the accepting edge.
- Output holding:
  - out, count and zero hold their last result until the next operation completes.
  - out and count are not updated while shifting; they change only on the edge entering DONE.
  - zero is cleared on accept of a nonzero word.
- done and busy come from state, registered only through the FSM, with no combinational path from start.
- Round-trip property: for nonzero x, barrel-shifting x left by count equals out, and out[N-1]==1.

Test Plan:
- in=8'b10011101, start pulse -> L=0; done high 2 cycles after the accept edge; out=8'b10011101, count=0, zero=0.
- in=8'b00101100 -> done high 4 cycles after accept; out=8'b10110000, count=2; busy high for exactly 4 cycles.
- in=8'b00000001 -> count=7, out=8'b10000000; done high 9 cycles after accept (worst case).
- in=8'b00000000 -> done high 1 cycle after accept; zero=1, out=0, count=0. A following nonzero op clears zero.
- start re-pulsed with in=8'hFF while busy on in=8'b00000001 -> second request ignored; result is still count=7. The next start is accepted only after busy falls.
- rst asserted asynchronously mid-SHIFT, between clock edges -> all outputs 0 immediately and state IDLE, with no done pulse. After release, in=8'b11100101 -> count=0, out=8'b11100101.
